// File: rtl/v_line_timing.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | v_line_timing: vertical line counter / sync generator driven by H_SYNC |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module v_line_timing #(
  parameter int V_SYNC_LINES   = 2,
  parameter int V_BACK_LINES   = 33,
  parameter int V_ACTIVE_LINES = 480,
  parameter int V_FRONT_LINES  = 10,
  parameter int H_TIMEOUT      = 1023
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       H_SYNC,
  output logic       V_SYNC,
  output logic       V_ACTIVE,
  output logic [9:0] LINE,
  output logic [8:0] ROW,
  output logic       FRAME_START,
  output logic       H_LOCK
);

  localparam logic [9:0] c_back_start  = 10'(V_SYNC_LINES);
  localparam logic [9:0] c_act_start   = 10'(V_SYNC_LINES + V_BACK_LINES);
  localparam logic [9:0] c_front_start = 10'(V_SYNC_LINES + V_BACK_LINES + V_ACTIVE_LINES);
  localparam logic [9:0] c_last_line   =
    10'(V_SYNC_LINES + V_BACK_LINES + V_ACTIVE_LINES + V_FRONT_LINES - 1);
  localparam logic [9:0] c_idle_max    = 10'd1023;
  localparam logic [9:0] c_timeout     = 10'(H_TIMEOUT);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_BACK   = 2'd1,
    S_ACTIVE = 2'd2,
    S_FRONT  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_h_q;
  logic [9:0] r_idle;
  logic       w_tick;
  logic [9:0] w_line_nxt;
  logic [9:0] w_idle_nxt;
  logic       w_lock_nxt;
  logic       w_vactive_nxt;
  logic [8:0] w_row_nxt;

  // A tick is the end of the sync pulse; all its effects land on this same edge.
  assign w_tick = H_SYNC & ~r_h_q;

  always_comb begin
    w_state_nxt   = r_state;
    w_line_nxt    = LINE;
    w_idle_nxt    = r_idle;
    w_lock_nxt    = H_LOCK;
    if (w_tick) begin
      w_line_nxt = (LINE >= c_last_line) ? 10'd0 : LINE + 10'd1;
      w_idle_nxt = 10'd0;
      w_lock_nxt = 1'b1;
      case (r_state)
        S_SYNC:   if (w_line_nxt == c_back_start)  w_state_nxt = S_BACK;
        S_BACK:   if (w_line_nxt == c_act_start)   w_state_nxt = S_ACTIVE;
        S_ACTIVE: if (w_line_nxt == c_front_start) w_state_nxt = S_FRONT;
        S_FRONT:  if (w_line_nxt == 10'd0)         w_state_nxt = S_SYNC;
        default:  w_state_nxt = S_SYNC;
      endcase
    end else begin
      if (r_idle != c_idle_max) w_idle_nxt = r_idle + 10'd1;
      if (w_idle_nxt >= c_timeout) w_lock_nxt = 1'b0;
    end
    // Losing lock blanks the picture but leaves the frame position intact.
    w_vactive_nxt = w_lock_nxt && (w_state_nxt == S_ACTIVE);
    w_row_nxt     = w_vactive_nxt ? 9'(w_line_nxt - c_act_start) : 9'd0;
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) r_state <= S_SYNC;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_h_q       <= 1'b1;
      r_idle      <= 10'd0;
      LINE        <= 10'd0;
      ROW         <= 9'd0;
      V_SYNC      <= 1'b0;
      V_ACTIVE    <= 1'b0;
      FRAME_START <= 1'b0;
      H_LOCK      <= 1'b0;
    end else begin
      r_h_q       <= H_SYNC;
      r_idle      <= w_idle_nxt;
      LINE        <= w_line_nxt;
      ROW         <= w_row_nxt;
      V_SYNC      <= (w_state_nxt != S_SYNC);
      V_ACTIVE    <= w_vactive_nxt;
      FRAME_START <= w_tick && (LINE >= c_last_line);
      H_LOCK      <= w_lock_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_v_line_timing.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_v_line_timing: scoreboard bench with a line-level reference model  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_v_line_timing;

  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic       H_SYNC = 1'b1;
  logic       V_SYNC;
  logic       V_ACTIVE;
  logic [9:0] LINE;
  logic [8:0] ROW;
  logic       FRAME_START;
  logic       H_LOCK;

  v_line_timing dut (
    .clk         (clk),
    .RESET       (RESET),
    .H_SYNC      (H_SYNC),
    .V_SYNC      (V_SYNC),
    .V_ACTIVE    (V_ACTIVE),
    .LINE        (LINE),
    .ROW         (ROW),
    .FRAME_START (FRAME_START),
    .H_LOCK      (H_LOCK)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vs;
    logic       va;
    logic [9:0] line;
    logic [8:0] row;
    logic       fs;
    logic       lock;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   fs_seen = 0;

  // Reference model: frame position as a plain integer line number.
  int   m_line;
  int   m_idle;
  bit   m_lock;
  bit   m_prev_h;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vsync"}, V_SYNC, 0);
    check({tag, "_vactive"}, V_ACTIVE, 0);
    check({tag, "_line"}, LINE, 0);
    check({tag, "_row"}, ROW, 0);
    check({tag, "_frame_start"}, FRAME_START, 0);
    check({tag, "_hlock"}, H_LOCK, 0);
  endtask

  function automatic void model_reset();
    m_line   = 0;
    m_idle   = 0;
    m_lock   = 0;
    m_prev_h = 1;
  endfunction

  // Drive one clock of H_SYNC and queue what the outputs must be after that edge.
  task automatic step(input bit h);
    bit   tick;
    bit   fs;
    bit   act;
    exp_t e;
    @(negedge clk);
    H_SYNC = h;
    @(posedge clk);
    tick     = h && !m_prev_h;
    m_prev_h = h;
    fs       = 0;
    if (tick) begin
      m_line = (m_line == 524) ? 0 : m_line + 1;
      fs     = (m_line == 0);
      m_idle = 0;
      m_lock = 1;
    end else begin
      if (m_idle < 1023) m_idle++;
      if (m_idle >= 1023) m_lock = 0;
    end
    act    = m_lock && (m_line >= 35) && (m_line < 515);
    e.vs   = (m_line >= 2);
    e.va   = act;
    e.line = 10'(m_line);
    e.row  = act ? 9'(m_line - 35) : 9'd0;
    e.fs   = fs;
    e.lock = m_lock;
    q.push_back(e);
  endtask

  task automatic pulse(input int period, input int low);
    repeat (low) step(1'b0);
    repeat (period - low) step(1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (FRAME_START) fs_seen++;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("vsync", V_SYNC, e.vs);
        check("vactive", V_ACTIVE, e.va);
        check("line", LINE, e.line);
        check("row", ROW, e.row);
        check("frame_start", FRAME_START, e.fs);
        check("hlock", H_LOCK, e.lock);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    RESET  = 1'b0;
    H_SYNC = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");

    // Release with H_SYNC already high: no tick may result.
    @(negedge clk);
    RESET = 1'b1;
    repeat (5) step(1'b1);

    fs_seen = 0;
    for (int i = 0; i < 525; i++) begin
      if (i < 3) pulse(801, 1 + (i % 3));
      else       pulse($urandom_range(4, 14), $urandom_range(1, 3));
    end
    check("frame_start_count", fs_seen, 1);

    repeat (300) step(1'($urandom_range(0, 1)));

    while (m_line != 100) pulse(6, 1);
    repeat (1100) step(1'b1);
    #1;
    check("timeout_line_held", LINE, 100);
    check("timeout_lock", H_LOCK, 0);
    pulse(6, 2);
    #1;
    check("relock_line", LINE, 101);
    check("relock_row", ROW, 66);

    while (m_line != 300) pulse($urandom_range(3, 9), 1);
    @(negedge clk);
    #2;
    RESET = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    repeat (2) @(negedge clk);
    RESET = 1'b1;
    repeat (4) step(1'b1);
    for (int i = 0; i < 40; i++) pulse($urandom_range(2, 8), 1);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/v_line_timing.md
V_LINE_TIMING -- requirements
Module: v_line_timing

Interface
REQ-001 SHALL have port: clk  input  1  pixel clock; all state updates on rising edge.
REQ-002 SHALL have port: RESET  input  1  asynchronous, active-low reset; one clock domain, no other clock.
REQ-003 SHALL have port: H_SYNC  input  1  horizontal sync from the line timing stage, synchronous to clk, active-low pulse once per line.
REQ-004 SHALL have port: V_SYNC  output  1  vertical sync, active-low, registered.
REQ-005 SHALL have port: V_ACTIVE  output  1  high during visible lines, registered.
REQ-006 SHALL have port: LINE  output  10  current line number 0..524, registered.
REQ-007 SHALL have port: ROW  output  9  visible row index 0..479 when V_ACTIVE=1, else 0, registered.
REQ-008 SHALL have port: FRAME_START  output  1  one-clock pulse when LINE wraps to 0.
REQ-009 SHALL have port: H_LOCK  output  1  high while H_SYNC line ticks arrive within the timeout.
REQ-010 SHALL have parameters: V_SYNC_LINES=2, V_BACK_LINES=33, V_ACTIVE_LINES=480, V_FRONT_LINES=10 (total 525); H_TIMEOUT=1023 clocks.

Function
REQ-011 SHALL register H_SYNC into h_q each clock; line tick = H_SYNC=1 and h_q=0 (rising edge, end of sync pulse).
REQ-012 SHALL apply all line-tick effects on the same clock edge at which the tick is detected (1 clock after H_SYNC rises at the input).
REQ-013 SHALL implement FSM states SYNC, BACK, ACTIVE, FRONT, advancing only on line ticks.
REQ-014 SHALL increment LINE by 1 per tick; at LINE=524 a tick sets LINE=0 and pulses FRAME_START for exactly one clock.
REQ-015 SHALL transition: SYNC->BACK when LINE becomes 2; BACK->ACTIVE when LINE becomes 35; ACTIVE->FRONT when LINE becomes 515; FRONT->SYNC when LINE becomes 0.
REQ-016 SHALL drive V_SYNC=0 in SYNC (lines 0-1), 1 otherwise.
REQ-017 SHALL drive V_ACTIVE=1 and ROW=LINE-35 in ACTIVE (lines 35-514); V_ACTIVE=0, ROW=0 elsewhere.
REQ-018 SHALL keep an idle counter, cleared on each tick, incremented each clock otherwise, saturating at 1023.
REQ-019 SHALL set H_LOCK=1 on any tick; clear H_LOCK when the idle counter reaches H_TIMEOUT.
REQ-020 SHALL, while H_LOCK=0, force V_ACTIVE=0 and ROW=0 but hold FSM state and LINE.
REQ-021 SHALL ignore H_SYNC held constant (no tick); a high-low-high glitch of any width counts as one tick.
REQ-022 SHALL use 10-bit LINE and idle counters; no value outside 0..524 / 0..1023 is ever reachable.

Reset
REQ-023 SHALL, on RESET=0, immediately (asynchronously) set: state=SYNC, LINE=0, ROW=0, V_SYNC=0, V_ACTIVE=0, FRAME_START=0, H_LOCK=0, idle counter=0, h_q=1.
REQ-024 SHALL not generate a tick on the first clock after reset release even if H_SYNC=1 (h_q reset to 1).
REQ-025 SHALL, on reset assertion mid-frame, abandon the frame; after release counting restarts at LINE=0 in SYNC.

Verification
REQ-026 SHALL cover: reset, then 525 H_SYNC pulses of period 801 clocks -> V_SYNC low for lines 0-1, V_ACTIVE high lines 35-514, exactly one FRAME_START at tick 525.
REQ-027 SHALL cover: tick at LINE=34 -> same edge LINE=35, V_ACTIVE=1, ROW=0; tick at LINE=514 -> LINE=515, V_ACTIVE=0, ROW=0.
REQ-028 SHALL cover: H_SYNC held high 1100 clocks while LINE=100 -> H_LOCK falls at idle count 1023, V_ACTIVE=0, LINE stays 100; next tick -> H_LOCK=1, LINE=101, V_ACTIVE=1, ROW=66.
REQ-029 SHALL cover: H_SYNC=1 during reset release -> no tick, LINE=0 until first genuine low-high edge.
REQ-030 SHALL cover: RESET asserted asynchronously at LINE=300 between clock edges -> all outputs at reset values before next clk edge.
REQ-031 SHALL cover: 1-clock-wide H_SYNC low pulse -> exactly one tick, LINE increments by 1.
